phase_ctrl: RTL

PHASE_CTRL -- requirements
Module: phase_ctrl

---
 rtl/hpu_pkg.sv | 13 +
 rtl/item_cnt.sv | 22 ++
 rtl/phase_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/hpu_pkg.sv
// hpu_pkg: shared phase-controller state encoding and default widths
package hpu_pkg;
    localparam int ITEM_W_DEF = 16;
    localparam int ADDR_W_DEF = 20;
    typedef enum logic [2:0] {
        S_IDLE,
        S_MATW,
        S_GAP,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;
endpackage

// File: rtl/item_cnt.sv
// item_cnt: item-memory write address counter with terminal-count compare
module item_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] last,
    output logic [W-1:0] cnt,
    output logic         tc
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr ? '0 : (inc ? cnt_q + W'(1) : cnt_q);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
    assign cnt = cnt_q;
    // Compare happens before the increment, so the all-ones bound stops without wrapping.
    assign tc  = cnt_q == last;
endmodule

// File: rtl/phase_ctrl.sv
// phase_ctrl: sequences item-memory write, compute/stream run and completion signalling
module phase_ctrl
    import hpu_pkg::*;
#(
    parameter int ITEM_W = ITEM_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              clear,
    input  logic [ITEM_W-1:0] cfg_item_num,
    input  logic [ADDR_W-1:0] cfg_addr_i,
    input  logic [ADDR_W-1:0] cfg_addr_j,
    input  logic              s_fin,
    input  logic              dst_valid,
    input  logic              dst_ready,
    input  logic              dst_last,
    output logic              matw,
    output logic              run,
    output logic [ITEM_W-1:0] mat_a,
    output logic [ADDR_W-1:0] addr_i,
    output logic [ADDR_W-1:0] addr_j,
    output logic              busy,
    output logic              done,
    output logic              irq
);
    state_e state_q, state_d;
    logic [ITEM_W-1:0] item_num_q, item_num_d;
    logic [ADDR_W-1:0] addr_i_q, addr_i_d, addr_j_q, addr_j_d;
    logic matw_q, matw_d, run_q, run_d, busy_q, busy_d, done_q, done_d, irq_q, irq_d;
    logic cnt_clr, cnt_inc, cnt_tc, hs;

    item_cnt #(.W(ITEM_W)) u_item_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .last (item_num_q),
        .cnt  (mat_a),
        .tc   (cnt_tc)
    );

    assign hs = dst_valid & dst_ready & dst_last;

    always_comb begin
        state_d    = state_q;
        item_num_d = item_num_q;
        addr_i_d   = addr_i_q;
        addr_j_d   = addr_j_q;
        done_d     = done_q & ~clear;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: if (start) begin
                    state_d    = S_MATW;
                    item_num_d = cfg_item_num;
                    addr_i_d   = cfg_addr_i;
                    addr_j_d   = cfg_addr_j;
                    done_d     = 1'b0;
                    cnt_clr    = 1'b1;
                end
                S_MATW: begin
                    cnt_clr = cnt_tc;
                    cnt_inc = !cnt_tc;
                    state_d = cnt_tc ? S_GAP : S_MATW;
                end
                S_GAP:   state_d = S_RUN;
                S_RUN:   state_d = s_fin ? (hs ? S_DONE : S_DRAIN) : S_RUN;
                S_DRAIN: state_d = hs ? S_DONE : S_DRAIN;
                default: state_d = S_IDLE;
            endcase
        end
        // Outputs are registered copies of the next-state decode.
        irq_d  = (state_d == S_DONE) && (state_q != S_DONE);
        done_d = done_d | irq_d;
        matw_d = state_d == S_MATW;
        run_d  = state_d inside {S_RUN, S_DRAIN};
        busy_d = !(state_d inside {S_IDLE, S_DONE});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            item_num_q <= '0;
            addr_i_q   <= '0;
            addr_j_q   <= '0;
            matw_q     <= 1'b0;
            run_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            item_num_q <= item_num_d;
            addr_i_q   <= addr_i_d;
            addr_j_q   <= addr_j_d;
            matw_q     <= matw_d;
            run_q      <= run_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            irq_q      <= irq_d;
        end
    end

    assign matw   = matw_q;
    assign run    = run_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign irq    = irq_q;
    assign addr_i = addr_i_q;
    assign addr_j = addr_j_q;
endmodule
